vx_writeback_arb: RTL and testbench
===================================

Name: vx_writeback_arb

Overview:
- Collects result packets from the execution units (ALU, LSU, FPU, SFU, TCU) of one issue slice and merges them into the single writeback stream consumed by the issue stage. The issue stage uses that stream for scoreboard release and register-file write.
- Sits directly upstream of the issue stage's writeback input. One instance per issue slice.
- Each input has a 2-entry elastic buffer. A round-robin arbiter drains one packet per cycle into a registered, valid-only output with no backpressure.

Parameters:
- NUM_INPUTS, 5, number of execution-unit result ports
- NUM_THREADS, 4, lanes per packet
- XLEN, 32, bits per lane
- NW_BITS, 2, warp-id width
- NR_BITS, 6, destination-register index width
- UUID_WIDTH, 44, instruction uuid width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NUM_INPUTS  per-input packet valid
- in_ready  out  NUM_INPUTS  per-input accept
- in_uuid  in  NUM_INPUTS*UUID_WIDTH  packet uuid
- in_wid  in  NUM_INPUTS*NW_BITS  warp id
- in_tmask  in  NUM_INPUTS*NUM_THREADS  thread mask
- in_rd  in  NUM_INPUTS*NR_BITS  destination register
- in_data  in  NUM_INPUTS*NUM_THREADS*XLEN  lane results
- in_eop  in  NUM_INPUTS  end of packet for multi-cycle results
- wb_valid  out  1  writeback valid (single-cycle pulse per packet)
- wb_uuid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop  out  (matching widths)  writeback payload
- wb_src  out  $clog2(NUM_INPUTS)  index of the granted input (debug)

Behaviour:
- Reset (reset=0, asynchronous):
  - all buffer counts = 0; in_ready = 0 while asserted.
  - wb_valid = 0; wb_* payload = 0; wb_src = 0.
  - last_grant = NUM_INPUTS-1, so input 0 has first priority after reset.
  - Reset mid-operation discards all buffered packets.
- Input buffer i (2 entries, FIFO order):
  - in_ready[i] = (count_i < 2), a function of registered state only; no combinational path from any other input or from the arbiter.
  - Push when in_valid[i] && in_ready[i]. Senders hold payload stable while valid && !ready.
  - A full buffer does not accept on a cycle it is popped; in_ready rises the cycle after the pop.
  - Simultaneous push and pop with count=1 leaves count=1 and preserves order.
- Arbiter (combinational on buffer heads):
  - Request i = (count_i != 0).
  - Grant the first requesting index searching (last_grant+1) mod N upward with wrap.
  - On grant: pop that head; last_grant <= grant. With no requests, last_grant holds.
- Output register:
  - On grant, the next edge loads the head payload into wb_*, sets wb_valid=1 and wb_src=grant. With no grant, wb_valid=0 and payload holds its last value.
  - Throughput: 1 packet/cycle aggregate.
  - Latency: a packet accepted at edge t appears on wb_* after edge t+1, provided it wins arbitration at its first opportunity.
- Packets are forwarded unmodified; wb_tmask may be 0 and is still forwarded.

Optional Feature:
- WB_ARB_PERF_EN defined:
  - Adds output perf_conflicts [43:0], a counter incremented each cycle where ≥2 requests are active.
  - Adds output perf_full_stalls [43:0], incremented each cycle where any in_valid[i] && !in_ready[i].
  - Both counters reset to 0 and wrap modulo 2^44.
- WB_ARB_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single input 2, 6 back-to-back packets with rd=1..6, one per cycle:
  - in_ready[2] stays 1 throughout.
  - wb_valid is high for 6 consecutive cycles starting 1 cycle after the first push.
  - wb_rd=1..6 in order; wb_src=2.
- Inputs 0,1,3 each push one packet in the same cycle immediately after reset:
  - wb_src sequence is 0,1,3 on consecutive cycles.
  - One further packet on input 0 then wins only after input 3.
- Input 4 pushes 3 packets while inputs 0-3 saturate the arbiter:
  - in_ready[4] drops to 0 after the 2nd push.
  - Packet 3 is held until a pop, is accepted the cycle after in_ready[4] rises, and retains FIFO order.
- Assert reset low for 1 cycle while 2 packets are buffered on input 1:
  - wb_valid is 0 immediately; both packets are dropped; no wb pulse follows.
  - After release, a new packet on input 1 appears with 1-cycle latency.
- Data integrity: wb_data, wb_tmask, wb_eop and wb_uuid exactly match the pushed values (e.g. data=0xDEADBEEF per lane, tmask=4'b1010, eop=0) for 1000 random pushes across all inputs; scoreboard checks per-input ordering.
- With WB_ARB_PERF_EN: 10 cycles with 3 simultaneous requesters give perf_conflicts=10 (while ≥2 remain pending); all counters are 0 after reset.

Source files
------------

// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: per-unit 2-entry elastic buffers merged round-robin into one registered stream.
// Define WB_ARB_PERF_EN to add the perf_conflicts / perf_full_stalls counters.
module vx_writeback_arb #(
    parameter int unsigned NUM_INPUTS  = 5,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 6,
    parameter int unsigned UUID_WIDTH  = 44,
    localparam int unsigned SRC_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_INPUTS-1:0]               in_valid,
    output logic [NUM_INPUTS-1:0]               in_ready,
    input  logic [NUM_INPUTS*UUID_WIDTH-1:0]    in_uuid,
    input  logic [NUM_INPUTS*NW_BITS-1:0]       in_wid,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0]   in_tmask,
    input  logic [NUM_INPUTS*NR_BITS-1:0]       in_rd,
    input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]               in_eop,
    output logic                                wb_valid,
    output logic [UUID_WIDTH-1:0]               wb_uuid,
    output logic [NW_BITS-1:0]                  wb_wid,
    output logic [NUM_THREADS-1:0]              wb_tmask,
    output logic [NR_BITS-1:0]                  wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]         wb_data,
    output logic                                wb_eop,
    output logic [SRC_W-1:0]                    wb_src
`ifdef WB_ARB_PERF_EN
    ,
    output logic [43:0]                         perf_conflicts,
    output logic [43:0]                         perf_full_stalls
`endif
);

    localparam int unsigned DATA_W = NUM_THREADS * XLEN;
    localparam int unsigned PKT_W  = UUID_WIDTH + NW_BITS + NUM_THREADS + NR_BITS + DATA_W + 1;

    typedef logic [PKT_W-1:0] pkt_t;

    pkt_t                  head [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] req;
    logic [NUM_INPUTS-1:0] push;
    logic [NUM_INPUTS-1:0] pop;

    logic [SRC_W-1:0]      last_grant_q;
    logic [SRC_W-1:0]      grant;
    logic                  grant_valid;
    pkt_t                  grant_pkt;

    pkt_t                  wb_pkt_q;
    logic                  wb_valid_q;
    logic [SRC_W-1:0]      wb_src_q;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_buf
        pkt_t       in_pkt;
        pkt_t       head_q;
        pkt_t       tail_q;
        logic [1:0] count_q;

        assign in_pkt = {in_uuid[i*UUID_WIDTH +: UUID_WIDTH],
                         in_wid[i*NW_BITS +: NW_BITS],
                         in_tmask[i*NUM_THREADS +: NUM_THREADS],
                         in_rd[i*NR_BITS +: NR_BITS],
                         in_data[i*DATA_W +: DATA_W],
                         in_eop[i]};

        // Ready depends only on this buffer's own registered count (and reset).
        assign in_ready[i] = reset && (count_q < 2'd2);
        assign push[i]     = in_valid[i] && in_ready[i];
        assign pop[i]      = grant_valid && (grant == SRC_W'(i));
        assign req[i]      = (count_q != 2'd0);
        assign head[i]     = head_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_q <= 2'd0;
                head_q  <= '0;
                tail_q  <= '0;
            end else begin
                case (count_q)
                    2'd0: begin
                        if (push[i]) begin
                            head_q  <= in_pkt;
                            count_q <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push[i] && pop[i]) begin
                            head_q <= in_pkt;
                        end else if (push[i]) begin
                            tail_q  <= in_pkt;
                            count_q <= 2'd2;
                        end else if (pop[i]) begin
                            count_q <= 2'd0;
                        end
                    end
                    default: begin
                        if (pop[i]) begin
                            head_q  <= tail_q;
                            count_q <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Round-robin: first requester strictly after the previous grant, with wrap.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_INPUTS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = SRC_W'(idx);
            end
        end
    end

    assign grant_pkt = head[grant];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= SRC_W'(NUM_INPUTS - 1);
            wb_valid_q   <= 1'b0;
            wb_pkt_q     <= '0;
            wb_src_q     <= '0;
        end else begin
            wb_valid_q <= grant_valid;
            if (grant_valid) begin
                last_grant_q <= grant;
                wb_pkt_q     <= grant_pkt;
                wb_src_q     <= grant;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_src   = wb_src_q;
    assign {wb_uuid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop} = wb_pkt_q;

`ifdef WB_ARB_PERF_EN
    logic [43:0] perf_conflicts_q;
    logic [43:0] perf_full_stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conflicts_q   <= '0;
            perf_full_stalls_q <= '0;
        end else begin
            if ($countones(req) >= 2) begin
                perf_conflicts_q <= perf_conflicts_q + 44'd1;
            end
            if (|(in_valid & ~in_ready)) begin
                perf_full_stalls_q <= perf_full_stalls_q + 44'd1;
            end
        end
    end

    assign perf_conflicts   = perf_conflicts_q;
    assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: directed tables/sequences plus random traffic vs. a queue model.
module tb_vx_writeback_arb;

    localparam int NI  = 5;
    localparam int NT  = 4;
    localparam int XL  = 32;
    localparam int NWB = 2;
    localparam int NRB = 6;
    localparam int UW  = 44;
    localparam int SW  = 3;

    typedef struct packed {
        logic [UW-1:0]    uuid;
        logic [NWB-1:0]   wid;
        logic [NT-1:0]    tmask;
        logic [NRB-1:0]   rd;
        logic [NT*XL-1:0] data;
        logic             eop;
    } pkt_t;

    typedef struct {
        logic [NI-1:0]  valid;
        logic [NRB-1:0] rd0;
        bit             exp_v;
        int             exp_src;
        logic [NRB-1:0] exp_rd;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NI-1:0]     in_valid = '0;
    logic [NI-1:0]     in_ready;
    logic [NI*UW-1:0]  in_uuid;
    logic [NI*NWB-1:0] in_wid;
    logic [NI*NT-1:0]  in_tmask;
    logic [NI*NRB-1:0] in_rd;
    logic [NI*NT*XL-1:0] in_data;
    logic [NI-1:0]     in_eop;
    logic              wb_valid;
    logic [UW-1:0]     wb_uuid;
    logic [NWB-1:0]    wb_wid;
    logic [NT-1:0]     wb_tmask;
    logic [NRB-1:0]    wb_rd;
    logic [NT*XL-1:0]  wb_data;
    logic              wb_eop;
    logic [SW-1:0]     wb_src;
`ifdef WB_ARB_PERF_EN
    logic [43:0]       perf_conflicts;
    logic [43:0]       perf_full_stalls;
`endif

    pkt_t drv [NI];
    pkt_t wb_act;

    for (genvar g = 0; g < NI; g++) begin : g_drv
        assign in_uuid[g*UW +: UW]       = drv[g].uuid;
        assign in_wid[g*NWB +: NWB]      = drv[g].wid;
        assign in_tmask[g*NT +: NT]      = drv[g].tmask;
        assign in_rd[g*NRB +: NRB]       = drv[g].rd;
        assign in_data[g*NT*XL +: NT*XL] = drv[g].data;
        assign in_eop[g]                 = drv[g].eop;
    end

    assign wb_act = {wb_uuid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop};

    vx_writeback_arb dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_uuid  (in_uuid),
        .in_wid   (in_wid),
        .in_tmask (in_tmask),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .in_eop   (in_eop),
        .wb_valid (wb_valid),
        .wb_uuid  (wb_uuid),
        .wb_wid   (wb_wid),
        .wb_tmask (wb_tmask),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_eop   (wb_eop),
        .wb_src   (wb_src)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflicts   (perf_conflicts),
        .perf_full_stalls (perf_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one FIFO queue per input, round-robin pointer, expected output.
    pkt_t          mq [NI][$];
    int            m_last;
    bit            exp_v;
    pkt_t          exp_p;
    int            exp_src;
    longint        m_conf;
    longint        m_stall;
    logic [NI-1:0] last_push;
    int            n_pushes;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t rnd_pkt();
        pkt_t p;
        p.uuid  = UW'({$urandom(), $urandom()});
        p.wid   = NWB'($urandom());
        p.tmask = NT'($urandom());
        p.rd    = NRB'($urandom());
        for (int l = 0; l < NT; l++) p.data[l*XL +: XL] = $urandom();
        p.eop   = 1'($urandom());
        if ($urandom_range(3) == 0) begin
            p.data  = {NT{32'hDEADBEEF}};
            p.tmask = 4'b1010;
            p.eop   = 1'b0;
        end
        return p;
    endfunction

    task automatic refresh(input int i, input int pct);
        drv[i]      = rnd_pkt();
        in_valid[i] = ($urandom_range(99) < pct);
    endtask

    // One clock: check ready, advance the model at the edge, then compare outputs.
    task automatic cycle();
        logic [NI-1:0] rdy;
        bit gv;
        int g;
        int nreq;
        bit stall;
        gv = 0;
        g = 0;
        nreq = 0;
        for (int i = 0; i < NI; i++) begin
            rdy[i] = (mq[i].size() < 2);
            if (mq[i].size() != 0) nreq++;
        end
        chk("in_ready", 256'(in_ready), 256'(rdy));
        stall = |(in_valid & ~rdy);
        for (int k = 1; k <= NI; k++) begin
            int idx;
            idx = (m_last + k) % NI;
            if (!gv && mq[idx].size() != 0) begin
                gv = 1;
                g  = idx;
            end
        end
        @(posedge clk);
        if (nreq >= 2) m_conf++;
        if (stall) m_stall++;
        exp_v = gv;
        if (gv) begin
            exp_p   = mq[g].pop_front();
            exp_src = g;
            m_last  = g;
        end
        last_push = '0;
        for (int i = 0; i < NI; i++) begin
            if (in_valid[i] && rdy[i]) begin
                mq[i].push_back(drv[i]);
                last_push[i] = 1'b1;
                n_pushes++;
            end
        end
        #1;
        chk("wb_valid", 256'(wb_valid), 256'(exp_v));
        chk("wb_payload", 256'(wb_act), 256'(exp_p));
        chk("wb_src", 256'(wb_src), 256'(exp_src));
`ifdef WB_ARB_PERF_EN
        chk("perf_conflicts", 256'(perf_conflicts), 256'(m_conf[43:0]));
        chk("perf_full_stalls", 256'(perf_full_stalls), 256'(m_stall[43:0]));
`endif
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = '0;
        #1;
        chk("rst_wb_valid_now", 256'(wb_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        for (int i = 0; i < NI; i++) mq[i].delete();
        m_last  = NI - 1;
        exp_v   = 0;
        exp_p   = '0;
        exp_src = 0;
        m_conf  = 0;
        m_stall = 0;
        @(posedge clk);
        #1;
        chk("rst_wb_valid", 256'(wb_valid), 256'(0));
        chk("rst_wb_src", 256'(wb_src), 256'(0));
        chk("rst_payload", 256'(wb_act), 256'(0));
`ifdef WB_ARB_PERF_EN
        chk("rst_perf_conf", 256'(perf_conflicts), 256'(0));
        chk("rst_perf_stall", 256'(perf_full_stalls), 256'(0));
`endif
        reset = 1'b1;
        #1;
    endtask

    initial begin
        vec_t tv [6];
        int   p4;
        int   got4;
        int   cyc;
        bit   saw_nr;

        for (int i = 0; i < NI; i++) drv[i] = '0;
        last_push = '0;
        n_pushes  = 0;

        // Three simultaneous requesters after reset, then a late packet on input 0.
        tv[0] = '{5'b01011, 6'd10, 1'b0, 0, 6'd0};
        tv[1] = '{5'b00001, 6'd20, 1'b1, 0, 6'd10};
        tv[2] = '{5'b00000, 6'd0,  1'b1, 1, 6'd11};
        tv[3] = '{5'b00000, 6'd0,  1'b1, 3, 6'd13};
        tv[4] = '{5'b00000, 6'd0,  1'b1, 0, 6'd20};
        tv[5] = '{5'b00000, 6'd0,  1'b0, 0, 6'd0};

        do_reset();

        // Back-to-back single input stream.
        for (int k = 1; k <= 6; k++) begin
            in_valid = 5'b00100;
            drv[2] = rnd_pkt();
            drv[2].rd = NRB'(k);
            chk("t1_ready2", 256'(in_ready[2]), 256'(1));
            cycle();
            if (k > 1) begin
                chk("t1_valid", 256'(wb_valid), 256'(1));
                chk("t1_rd", 256'(wb_rd), 256'(k - 1));
                chk("t1_src", 256'(wb_src), 256'(2));
            end
        end
        in_valid = '0;
        cycle();
        chk("t1_last_rd", 256'(wb_rd), 256'(6));
        chk("t1_last_valid", 256'(wb_valid), 256'(1));
        cycle();
        chk("t1_idle", 256'(wb_valid), 256'(0));

        do_reset();
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NI; i++) begin
                drv[i] = rnd_pkt();
                drv[i].rd = NRB'(10 + i);
            end
            drv[0].rd = tv[v].rd0;
            in_valid = tv[v].valid;
            cycle();
            chk("t2_valid", 256'(wb_valid), 256'(tv[v].exp_v));
            if (tv[v].exp_v) begin
                chk("t2_src", 256'(wb_src), 256'(tv[v].exp_src));
                chk("t2_rd", 256'(wb_rd), 256'(tv[v].exp_rd));
            end
        end

        // Input 4 fills its buffer while inputs 0-3 keep the arbiter busy.
        do_reset();
        p4 = 1;
        got4 = 0;
        saw_nr = 0;
        for (int i = 0; i < 4; i++) refresh(i, 100);
        drv[4] = rnd_pkt();
        drv[4].rd = NRB'(40 + p4);
        in_valid[4] = 1'b1;
        cyc = 0;
        while (got4 < 3 && cyc < 60) begin
            cycle();
            cyc++;
            if (wb_valid && wb_src == 3'd4) begin
                chk("t3_order", 256'(wb_rd), 256'(41 + got4));
                got4++;
            end
            for (int i = 0; i < 4; i++) if (last_push[i]) refresh(i, 100);
            if (last_push[4]) begin
                if (p4 == 2) begin
                    chk("t3_full_ready4", 256'(in_ready[4]), 256'(0));
                    saw_nr = 1;
                end
                p4++;
                drv[4] = rnd_pkt();
                drv[4].rd = NRB'(40 + p4);
                in_valid[4] = (p4 <= 3);
            end
        end
        chk("t3_delivered", 256'(got4), 256'(3));
        chk("t3_saw_full", 256'(saw_nr), 256'(1));
        in_valid = '0;
        repeat (10) cycle();

        // Reset while two packets sit in input 1's buffer.
        do_reset();
        in_valid = 5'b00011;
        drv[0] = rnd_pkt();
        drv[0].rd = 6'd1;
        drv[1] = rnd_pkt();
        drv[1].rd = 6'd2;
        cycle();
        in_valid = 5'b00010;
        drv[1] = rnd_pkt();
        drv[1].rd = 6'd3;
        cycle();
        chk("t4_full1", 256'(in_ready[1]), 256'(0));
        do_reset();
        repeat (3) begin
            cycle();
            chk("t4_no_pulse", 256'(wb_valid), 256'(0));
        end
        in_valid = 5'b00010;
        drv[1] = rnd_pkt();
        drv[1].rd = 6'd5;
        cycle();
        chk("t4_lat0", 256'(wb_valid), 256'(0));
        in_valid = '0;
        cycle();
        chk("t4_lat1_valid", 256'(wb_valid), 256'(1));
        chk("t4_lat1_src", 256'(wb_src), 256'(1));
        chk("t4_lat1_rd", 256'(wb_rd), 256'(5));

`ifdef WB_ARB_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) refresh(i, 100);
        cycle();
        repeat (10) begin
            cycle();
            for (int i = 0; i < 3; i++) if (last_push[i]) refresh(i, 100);
        end
        chk("perf_10_conflicts", 256'(perf_conflicts), 256'(10));
        in_valid = '0;
        repeat (5) cycle();
`endif

        // Random traffic on all inputs against the queue model.
        do_reset();
        n_pushes = 0;
        for (int i = 0; i < NI; i++) refresh(i, 60);
        cyc = 0;
        while (n_pushes < 1000 && cyc < 5000) begin
            cycle();
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (last_push[i] || !in_valid[i]) refresh(i, 60);
            end
        end
        chk("rand_push_count", 256'(n_pushes >= 1000), 256'(1));
        in_valid = '0;
        repeat (12) cycle();
        chk("rand_drained", 256'(wb_valid), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
